calc_entry_fsm: RTL



---
 rtl/calc_pkg.sv | 29 ++
 rtl/btn_debounce.sv | 58 +++++
 rtl/calc_entry_fsm.sv | 101 ++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | calc_pkg: shared encodings for the calculator entry and ALU side |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package calc_pkg;

  localparam int OPERAND_W = 8;

  typedef enum logic [2:0] {
    S_NUM1 = 3'd0,
    S_NUM2 = 3'd1,
    S_OP   = 3'd2,
    S_SHOW = 3'd3
  } state_e;

  localparam logic [2:0] OP_XOR = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_SUM = 3'd3;
  localparam logic [2:0] OP_DIF = 3'd4;
  localparam logic [2:0] OP_MAX = OP_DIF;

  function automatic logic op_valid(input logic [2:0] code);
    return (code <= OP_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btn_debounce: 2-FF synchronizer, stable-count filter, press pulse|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Only the rising level change is a press; release is silent.
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/calc_entry_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | calc_entry_fsm: button-stepped entry of operand 1/2 and op code  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btnr,
  input  logic [OPERAND_W-1:0] sw,
  output logic [OPERAND_W-1:0] num1,
  output logic [OPERAND_W-1:0] num2,
  output logic [2:0]           op_sel,
  output logic [2:0]           state,
  output logic                 ans_valid,
  output logic                 op_err
);

  logic press;
  logic level;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btnr),
    .level  (level),
    .press  (press)
  );

  state_e               state_q, state_d;
  logic [OPERAND_W-1:0] num1_q, num1_d;
  logic [OPERAND_W-1:0] num2_q, num2_d;
  logic [2:0]           op_sel_q, op_sel_d;
  logic                 ans_valid_q, ans_valid_d;
  logic                 op_err_q, op_err_d;

  always_comb begin
    state_d  = state_q;
    num1_d   = num1_q;
    num2_d   = num2_q;
    op_sel_d = op_sel_q;
    op_err_d = 1'b0;
    case (state_q)
      S_NUM1: if (press) begin
        num1_d  = sw;
        state_d = S_NUM2;
      end
      S_NUM2: if (press) begin
        num2_d  = sw;
        state_d = S_OP;
      end
      S_OP: if (press) begin
        if (op_valid(sw[2:0])) begin
          op_sel_d = sw[2:0];
          state_d  = S_SHOW;
        end else begin
          op_err_d = 1'b1;
        end
      end
      S_SHOW: if (press) begin
        state_d = S_NUM1;
      end
      // Unreachable encodings recover on the next clock.
      default: state_d = S_NUM1;
    endcase
    ans_valid_d = (state_d == S_SHOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_NUM1;
      num1_q      <= '0;
      num2_q      <= '0;
      op_sel_q    <= OP_XOR;
      ans_valid_q <= 1'b0;
      op_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      op_sel_q    <= op_sel_d;
      ans_valid_q <= ans_valid_d;
      op_err_q    <= op_err_d;
    end
  end

  assign num1      = num1_q;
  assign num2      = num2_q;
  assign op_sel    = op_sel_q;
  assign state     = state_q;
  assign ans_valid = ans_valid_q;
  assign op_err    = op_err_q;

endmodule
`default_nettype wire
